tlb_mmu: RTL and testbench

Joint TLB and address translation unit for the MIPS32 core, directly upstream of the CP0 exception block. Translates fetch (F) and data (E) virtual addresses, raises the refill, invalid and modify flags that CP0 prioritises, and executes tlbp/tlbr/tlbwi/tlbwr. It consumes CP0's EntryHi, EntryLo0/1, PageMask, Index and Random outputs, and returns probe and read results on CP0's `*_in` ports.

---
 rtl/tlb_pkg.sv | 55 +++++
 rtl/tlb_lookup.sv | 46 ++++
 rtl/tlb_mmu.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_tlb_mmu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - TLB entry type, CP0 register field positions and segment decode
package tlb_pkg;

    // CP0 EntryLo / EntryHi / PageMask bit positions
    localparam int LO_PFN_HI   = 25;
    localparam int LO_PFN_LO   = 6;
    localparam int LO_C_HI     = 5;
    localparam int LO_C_LO     = 3;
    localparam int LO_D        = 2;
    localparam int LO_V        = 1;
    localparam int LO_G        = 0;
    localparam int HI_VPN2_HI  = 31;
    localparam int HI_VPN2_LO  = 13;
    localparam int HI_ASID_HI  = 7;
    localparam int HI_ASID_LO  = 0;
    localparam int MASK_HI     = 24;
    localparam int MASK_LO     = 13;

    localparam logic [2:0] CCA_CACHED = 3'd3;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        SEG_KUSEG,
        SEG_KSEG0,
        SEG_KSEG1,
        SEG_KSEG23
    } seg_e;

    // Decode from va[31:29]
    function automatic seg_e seg_decode(input logic [2:0] va_top);
        if (!va_top[2])     return SEG_KUSEG;
        else if (va_top[1]) return SEG_KSEG23;
        else if (va_top[0]) return SEG_KSEG1;
        else                return SEG_KSEG0;
    endfunction

    function automatic logic seg_mapped(input seg_e s);
        return (s == SEG_KUSEG) || (s == SEG_KSEG23);
    endfunction

endpackage

// File: rtl/tlb_lookup.sv
// rtl/tlb_lookup.sv - combinational match of one VA page tag against all TLB entries
// Ports: entries (array), va_tag = va[31:12], asid; outputs hit, idx and the
// selected page's pfn/c/d/v plus the entry's G bit.
module tlb_lookup
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16
) (
    input  tlb_entry_t  entries [TLBNUM],
    input  logic [19:0] va_tag,
    input  logic [7:0]  asid,
    output logic        hit,
    output logic [4:0]  idx,
    output logic [19:0] pfn,
    output logic [2:0]  c,
    output logic        d,
    output logic        v,
    output logic        g
);

    logic unused_mask;

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit         = 1'b0;
        idx         = 5'd0;
        pfn         = 20'd0;
        c           = 3'd0;
        d           = 1'b0;
        v           = 1'b0;
        g           = 1'b0;
        unused_mask = 1'b0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            unused_mask = unused_mask ^ (^entries[i].mask);
            if (entries[i].vpn2 == va_tag[19:1] &&
                (entries[i].g || entries[i].asid == asid)) begin
                hit = 1'b1;
                idx = 5'(i);
                g   = entries[i].g;
                if (va_tag[0]) {pfn, c, d, v} = {entries[i].pfn1, entries[i].c1, entries[i].d1, entries[i].v1};
                else           {pfn, c, d, v} = {entries[i].pfn0, entries[i].c0, entries[i].d0, entries[i].v0};
            end
        end
    end

endmodule

// File: rtl/tlb_mmu.sv
// rtl/tlb_mmu.sv - MIPS32 joint TLB: fetch/data translation, tlbp/tlbr/tlbwi/tlbwr
// Ports: clk, rst (async active-low), stall_i; fetch inst_* and data data_* request/
// translation ports; k0; tlb_typeE {tlbwr,tlbwi,tlbr,tlbp}; CP0 register inputs *_W,
// random_i; tlbr/tlbp results *_out. Macro ITLB_CACHE_EN adds a one-entry fetch uTLB.
module tlb_mmu
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        inst_req,
    input  logic [31:0] inst_vaddr,
    output logic [31:0] inst_paddr,
    output logic        inst_uncached,
    output logic        inst_tlb_refill,
    output logic        inst_tlb_invalid,
    output logic        inst_stall,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_vaddr,
    output logic [31:0] data_paddr,
    output logic        data_uncached,
    output logic        data_tlb_refill,
    output logic        data_tlb_invalid,
    output logic        data_tlb_modify,
    input  logic [2:0]  k0,
    input  logic [3:0]  tlb_typeE,
    input  logic [31:0] entry_hi_W,
    input  logic [31:0] entry_lo0_W,
    input  logic [31:0] entry_lo1_W,
    input  logic [31:0] page_mask_W,
    input  logic [31:0] index_W,
    input  logic [31:0] random_i,
    output logic [31:0] entry_hi_out,
    output logic [31:0] entry_lo0_out,
    output logic [31:0] entry_lo1_out,
    output logic [31:0] page_mask_out,
    output logic [31:0] index_out
);

    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

    tlb_entry_t entries_q [TLBNUM];
    tlb_entry_t entries_d [TLBNUM];
    tlb_entry_t wentry;
    tlb_entry_t rentry;
    logic          we;
    logic [IW-1:0] widx;
    logic [7:0]    cur_asid;

    assign cur_asid = entry_hi_W[HI_ASID_HI:HI_ASID_LO];

    // ---------------- entry array and writes ----------------
    always_comb begin
        we          = (tlb_typeE[2] | tlb_typeE[3]) & ~stall_i;
        widx        = tlb_typeE[2] ? index_W[IW-1:0] : random_i[IW-1:0];
        wentry.vpn2 = entry_hi_W[HI_VPN2_HI:HI_VPN2_LO];
        wentry.asid = cur_asid;
        wentry.mask = page_mask_W[MASK_HI:MASK_LO];
        wentry.g    = entry_lo0_W[LO_G] & entry_lo1_W[LO_G];
        wentry.pfn0 = entry_lo0_W[LO_PFN_HI:LO_PFN_LO];
        wentry.c0   = entry_lo0_W[LO_C_HI:LO_C_LO];
        wentry.d0   = entry_lo0_W[LO_D];
        wentry.v0   = entry_lo0_W[LO_V];
        wentry.pfn1 = entry_lo1_W[LO_PFN_HI:LO_PFN_LO];
        wentry.c1   = entry_lo1_W[LO_C_HI:LO_C_LO];
        wentry.d1   = entry_lo1_W[LO_D];
        wentry.v1   = entry_lo1_W[LO_V];
        entries_d   = entries_q;
        if (we) entries_d[widx] = wentry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) entries_q[i] <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) entries_q[i] <= entries_d[i];
        end
    end

    // ---------------- lookups ----------------
    logic        d_hit, d_d, d_v, d_g;
    logic [4:0]  d_idx;
    logic [19:0] d_pfn;
    logic [2:0]  d_c;
    logic        p_hit, p_d, p_v, p_g;
    logic [4:0]  p_idx;
    logic [19:0] p_pfn;
    logic [2:0]  p_c;
    logic        il_hit, il_d, il_v, il_g;
    logic [4:0]  il_idx;
    logic [19:0] il_pfn;
    logic [2:0]  il_c;

    tlb_lookup #(.TLBNUM(TLBNUM)) u_data_lookup (
        .entries(entries_q), .va_tag(data_vaddr[31:12]), .asid(cur_asid),
        .hit(d_hit), .idx(d_idx), .pfn(d_pfn), .c(d_c), .d(d_d), .v(d_v), .g(d_g)
    );

    tlb_lookup #(.TLBNUM(TLBNUM)) u_probe_lookup (
        .entries(entries_q), .va_tag({entry_hi_W[31:13], 1'b0}), .asid(cur_asid),
        .hit(p_hit), .idx(p_idx), .pfn(p_pfn), .c(p_c), .d(p_d), .v(p_v), .g(p_g)
    );

    tlb_lookup #(.TLBNUM(TLBNUM)) u_inst_lookup (
        .entries(entries_q), .va_tag(inst_vaddr[31:12]), .asid(cur_asid),
        .hit(il_hit), .idx(il_idx), .pfn(il_pfn), .c(il_c), .d(il_d), .v(il_v), .g(il_g)
    );

    // ---------------- data path ----------------
    seg_e d_seg;
    logic d_mapped;

    always_comb begin
        d_seg            = seg_decode(data_vaddr[31:29]);
        d_mapped         = seg_mapped(d_seg);
        data_paddr       = d_mapped ? {d_pfn, data_vaddr[11:0]} : {3'b0, data_vaddr[28:0]};
        data_uncached    = d_mapped ? (d_c != CCA_CACHED)
                                    : ((d_seg == SEG_KSEG1) || (k0 != CCA_CACHED));
        data_tlb_refill  = rst & data_req & d_mapped & ~d_hit;
        data_tlb_invalid = rst & data_req & d_mapped & d_hit & ~d_v;
        data_tlb_modify  = rst & data_req & d_mapped & d_hit & d_v & data_wr & ~d_d;
    end

    // ---------------- probe and read ----------------
    always_comb begin
        rentry        = entries_q[tlb_typeE[1] ? index_W[IW-1:0] : '0];
        index_out     = {~p_hit, 26'd0, p_idx};
        entry_hi_out  = {rentry.vpn2, 5'd0, rentry.asid};
        entry_lo0_out = {6'd0, rentry.pfn0, rentry.c0, rentry.d0, rentry.v0, rentry.g};
        entry_lo1_out = {6'd0, rentry.pfn1, rentry.c1, rentry.d1, rentry.v1, rentry.g};
        page_mask_out = {7'd0, rentry.mask, 13'd0};
    end

    // ---------------- fetch path ----------------
    seg_e        i_seg;
    logic        i_mapped;
    logic        i_hit, i_v, i_stall;
    logic [19:0] i_pfn;
    logic [2:0]  i_c;

`ifdef ITLB_CACHE_EN
    typedef enum logic {ITLB_IDLE, ITLB_FILL} itlb_state_e;

    itlb_state_e state_q, state_d;
    logic        utlb_valid_q, utlb_valid_d;
    logic [19:0] utlb_tag_q, utlb_tag_d;
    logic [7:0]  utlb_asid_q, utlb_asid_d;
    logic        utlb_g_q, utlb_g_d;
    logic [19:0] utlb_pfn_q, utlb_pfn_d;
    logic [2:0]  utlb_c_q, utlb_c_d;
    logic        utlb_v_q, utlb_v_d;
    logic        fill_hit_q, fill_hit_d;
    logic        fill_ok_q, fill_ok_d;
    logic [19:0] fill_tag_q, fill_tag_d;
    logic [7:0]  fill_asid_q, fill_asid_d;
    logic        fill_g_q, fill_g_d;
    logic [19:0] fill_pfn_q, fill_pfn_d;
    logic [2:0]  fill_c_q, fill_c_d;
    logic        fill_v_q, fill_v_d;
    logic        utlb_hit;

    // The uTLB holds one 4 KB page (tag = va[31:12]) so the odd/even choice is baked in.
    always_comb begin
        state_d      = state_q;
        utlb_valid_d = utlb_valid_q;
        utlb_tag_d   = utlb_tag_q;
        utlb_asid_d  = utlb_asid_q;
        utlb_g_d     = utlb_g_q;
        utlb_pfn_d   = utlb_pfn_q;
        utlb_c_d     = utlb_c_q;
        utlb_v_d     = utlb_v_q;
        fill_hit_d   = fill_hit_q;
        fill_ok_d    = fill_ok_q;
        fill_tag_d   = fill_tag_q;
        fill_asid_d  = fill_asid_q;
        fill_g_d     = fill_g_q;
        fill_pfn_d   = fill_pfn_q;
        fill_c_d     = fill_c_q;
        fill_v_d     = fill_v_q;
        i_seg        = seg_decode(inst_vaddr[31:29]);
        i_mapped     = seg_mapped(i_seg);
        utlb_hit     = utlb_valid_q && (utlb_tag_q == inst_vaddr[31:12]) &&
                       (utlb_g_q || utlb_asid_q == cur_asid);
        i_hit        = il_hit;
        i_pfn        = il_pfn;
        i_c          = il_c;
        i_v          = il_v;
        i_stall      = 1'b0;
        case (state_q)
            ITLB_IDLE: begin
                if (inst_req && i_mapped) begin
                    if (utlb_hit) begin
                        i_hit = 1'b1;
                        i_pfn = utlb_pfn_q;
                        i_c   = utlb_c_q;
                        i_v   = utlb_v_q;
                    end else begin
                        i_stall     = 1'b1;
                        fill_hit_d  = il_hit;
                        // A write on the latch edge would leave the result stale.
                        fill_ok_d   = ~we;
                        fill_tag_d  = inst_vaddr[31:12];
                        fill_asid_d = cur_asid;
                        fill_g_d    = il_g;
                        fill_pfn_d  = il_pfn;
                        fill_c_d    = il_c;
                        fill_v_d    = il_v;
                        state_d     = ITLB_FILL;
                    end
                end
            end
            default: begin
                i_hit   = fill_hit_q;
                i_pfn   = fill_pfn_q;
                i_c     = fill_c_q;
                i_v     = fill_v_q;
                state_d = ITLB_IDLE;
                if (fill_hit_q && fill_ok_q && !we) begin
                    utlb_valid_d = 1'b1;
                    utlb_tag_d   = fill_tag_q;
                    utlb_asid_d  = fill_asid_q;
                    utlb_g_d     = fill_g_q;
                    utlb_pfn_d   = fill_pfn_q;
                    utlb_c_d     = fill_c_q;
                    utlb_v_d     = fill_v_q;
                end
            end
        endcase
        if (we) utlb_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ITLB_IDLE;
            utlb_valid_q <= 1'b0;
            utlb_tag_q   <= '0;
            utlb_asid_q  <= '0;
            utlb_g_q     <= 1'b0;
            utlb_pfn_q   <= '0;
            utlb_c_q     <= '0;
            utlb_v_q     <= 1'b0;
            fill_hit_q   <= 1'b0;
            fill_ok_q    <= 1'b0;
            fill_tag_q   <= '0;
            fill_asid_q  <= '0;
            fill_g_q     <= 1'b0;
            fill_pfn_q   <= '0;
            fill_c_q     <= '0;
            fill_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            utlb_valid_q <= utlb_valid_d;
            utlb_tag_q   <= utlb_tag_d;
            utlb_asid_q  <= utlb_asid_d;
            utlb_g_q     <= utlb_g_d;
            utlb_pfn_q   <= utlb_pfn_d;
            utlb_c_q     <= utlb_c_d;
            utlb_v_q     <= utlb_v_d;
            fill_hit_q   <= fill_hit_d;
            fill_ok_q    <= fill_ok_d;
            fill_tag_q   <= fill_tag_d;
            fill_asid_q  <= fill_asid_d;
            fill_g_q     <= fill_g_d;
            fill_pfn_q   <= fill_pfn_d;
            fill_c_q     <= fill_c_d;
            fill_v_q     <= fill_v_d;
        end
    end
`else
    always_comb begin
        i_seg    = seg_decode(inst_vaddr[31:29]);
        i_mapped = seg_mapped(i_seg);
        i_hit    = il_hit;
        i_pfn    = il_pfn;
        i_c      = il_c;
        i_v      = il_v;
        i_stall  = 1'b0;
    end
`endif

    always_comb begin
        inst_paddr       = i_mapped ? {i_pfn, inst_vaddr[11:0]} : {3'b0, inst_vaddr[28:0]};
        inst_uncached    = i_mapped ? (i_c != CCA_CACHED)
                                    : ((i_seg == SEG_KSEG1) || (k0 != CCA_CACHED));
        inst_stall       = rst & i_stall;
        inst_tlb_refill  = rst & inst_req & i_mapped & ~i_stall & ~i_hit;
        inst_tlb_invalid = rst & inst_req & i_mapped & ~i_stall & i_hit & ~i_v;
    end

    logic unused_ok;
    assign unused_ok = ^{tlb_typeE[0], index_W, random_i, entry_hi_W[12:8],
                         entry_lo0_W[31:26], entry_lo1_W[31:26], page_mask_W,
                         d_idx, d_g, p_pfn, p_c, p_d, p_v, p_g, il_idx, il_d, il_g};

endmodule

// File: tb/tb_tlb_mmu.sv
// tb/tb_tlb_mmu.sv - self-checking bench for tlb_mmu
module tb_tlb_mmu;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic [31:0] inst_paddr;
    logic        inst_uncached, inst_tlb_refill, inst_tlb_invalid, inst_stall;
    logic        data_req, data_wr;
    logic [31:0] data_vaddr;
    logic [31:0] data_paddr;
    logic        data_uncached, data_tlb_refill, data_tlb_invalid, data_tlb_modify;
    logic [2:0]  k0;
    logic [3:0]  tlb_typeE;
    logic [31:0] entry_hi_W, entry_lo0_W, entry_lo1_W, page_mask_W, index_W, random_i;
    logic [31:0] entry_hi_out, entry_lo0_out, entry_lo1_out, page_mask_out, index_out;

    int checks = 0;
    int errors = 0;

`ifdef ITLB_CACHE_EN
    localparam int MISS_STALL = 1;
`else
    localparam int MISS_STALL = 0;
`endif

    tlb_mmu #(.TLBNUM(16)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr),
        .inst_uncached(inst_uncached), .inst_tlb_refill(inst_tlb_refill),
        .inst_tlb_invalid(inst_tlb_invalid), .inst_stall(inst_stall),
        .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
        .data_paddr(data_paddr), .data_uncached(data_uncached),
        .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
        .data_tlb_modify(data_tlb_modify), .k0(k0), .tlb_typeE(tlb_typeE),
        .entry_hi_W(entry_hi_W), .entry_lo0_W(entry_lo0_W), .entry_lo1_W(entry_lo1_W),
        .page_mask_W(page_mask_W), .index_W(index_W), .random_i(random_i),
        .entry_hi_out(entry_hi_out), .entry_lo0_out(entry_lo0_out),
        .entry_lo1_out(entry_lo1_out), .page_mask_out(page_mask_out), .index_out(index_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] va;
        logic [2:0]  k0v;
        logic [7:0]  asid;
        logic        chk_pa;
        logic [31:0] pa;
        logic        unc;
        logic        refill;
        logic        inv;
        logic        modify;
    } dvec_t;

    dvec_t dv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tlbw(input logic wr, input logic [31:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1,
                        input logic [31:0] mask, input logic stall);
        entry_hi_W  = hi;
        entry_lo0_W = lo0;
        entry_lo1_W = lo1;
        page_mask_W = mask;
        if (wr) random_i = idx;
        else    index_W  = idx;
        stall_i   = stall;
        tlb_typeE = wr ? 4'b1000 : 4'b0100;
        @(posedge clk); #1;
        tlb_typeE = 4'b0000;
        stall_i   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] va, input logic [7:0] asid,
                         output logic [31:0] pa, output logic unc, output logic rf,
                         output logic iv, output int stalls);
        entry_hi_W = {entry_hi_W[31:8], asid};
        inst_vaddr = va;
        inst_req   = 1'b1;
        stalls     = 0;
        @(negedge clk);
        while (inst_stall && stalls < 4) begin
            stalls++;
            @(negedge clk);
        end
        pa  = inst_paddr;
        unc = inst_uncached;
        rf  = inst_tlb_refill;
        iv  = inst_tlb_invalid;
        @(posedge clk); #1;
        inst_req = 1'b0;
    endtask

    logic [31:0] pa;
    logic        unc, rf, iv;
    int          st;

    initial begin
        rst = 1'b0; stall_i = 1'b0; inst_req = 1'b0; inst_vaddr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_vaddr = '0; k0 = 3'd3; tlb_typeE = '0;
        entry_hi_W = '0; entry_lo0_W = '0; entry_lo1_W = '0; page_mask_W = '0;
        index_W = '0; random_i = '0;

        // hi 0x00400005 -> VPN2 of va 0x00400000..0x00401FFF, ASID 5
        dv[0]  = '{1'b1, 1'b1, 32'h00401ABC, 3'd3, 8'd9, 1'b1, 32'h12345ABC, 1'b0, 1'b0, 1'b0, 1'b1};
        dv[1]  = '{1'b1, 1'b0, 32'h00401ABC, 3'd3, 8'd9, 1'b1, 32'h12345ABC, 1'b0, 1'b0, 1'b0, 1'b0};
        dv[2]  = '{1'b1, 1'b0, 32'h00400ABC, 3'd3, 8'd9, 1'b1, 32'h00000ABC, 1'b1, 1'b0, 1'b1, 1'b0};
        dv[3]  = '{1'b1, 1'b1, 32'h00400ABC, 3'd3, 8'd9, 1'b1, 32'h00000ABC, 1'b1, 1'b0, 1'b1, 1'b0};
        dv[4]  = '{1'b1, 1'b0, 32'hA0001000, 3'd3, 8'd9, 1'b1, 32'h00001000, 1'b1, 1'b0, 1'b0, 1'b0};
        dv[5]  = '{1'b1, 1'b1, 32'h80001000, 3'd3, 8'd9, 1'b1, 32'h00001000, 1'b0, 1'b0, 1'b0, 1'b0};
        dv[6]  = '{1'b1, 1'b0, 32'h80001000, 3'd2, 8'd9, 1'b1, 32'h00001000, 1'b1, 1'b0, 1'b0, 1'b0};
        dv[7]  = '{1'b1, 1'b0, 32'h10000000, 3'd3, 8'd9, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        dv[8]  = '{1'b0, 1'b1, 32'h10000000, 3'd3, 8'd9, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        dv[9]  = '{1'b1, 1'b1, 32'hC0000000, 3'd3, 8'd9, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        dv[10] = '{1'b1, 1'b0, 32'h00000000, 3'd3, 8'd0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        dv[11] = '{1'b1, 1'b0, 32'h00000000, 3'd3, 8'd4, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};

        // Outputs while reset is held
        repeat (2) @(posedge clk);
        #1;
        inst_req = 1'b1; data_req = 1'b1;
        @(negedge clk);
        check("rst_inst_flags", {inst_tlb_refill, inst_tlb_invalid, inst_stall}, 0);
        check("rst_data_flags", {data_tlb_refill, data_tlb_invalid, data_tlb_modify}, 0);
        check("rst_inst_paddr", inst_paddr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;

        // Zeroed entries: va 0 with ASID 0 matches entry 0 with V=0
        fetch(32'h0, 8'd0, pa, unc, rf, iv, st);
        check("rst_fetch_flags", {rf, iv}, 2'b01);
        check("rst_fetch_stall", st, MISS_STALL);

        // Write then fetch
        tlbw(1'b0, 3, 32'h00400005, 32'h0, 32'h0048D15E, 32'h0, 1'b0);
        fetch(32'h00401ABC, 8'd5, pa, unc, rf, iv, st);
        check("wf_paddr", pa, 32'h12345ABC);
        check("wf_flags", {unc, rf, iv}, 3'b000);
        check("wf_stall1", st, MISS_STALL);
        fetch(32'h00401ABC, 8'd5, pa, unc, rf, iv, st);
        check("wf_paddr2", pa, 32'h12345ABC);
        check("wf_stall2", st, 0);

        // ASID mismatch, then global
        fetch(32'h00401ABC, 8'd6, pa, unc, rf, iv, st);
        check("asid_refill", {rf, iv}, 2'b10);
        tlbw(1'b0, 3, 32'h00400005, 32'h00000001, 32'h0048D15F, 32'h0, 1'b0);
        fetch(32'h00401ABC, 8'd6, pa, unc, rf, iv, st);
        check("global_paddr", pa, 32'h12345ABC);
        check("global_flags", {rf, iv}, 2'b00);
        check("global_stall", st, MISS_STALL);

        // Clean page with nonzero PageMask, then the data vector table
        tlbw(1'b0, 3, 32'h00400005, 32'h00000001, 32'h0048D15B, 32'h0001E000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            data_req = dv[i].req; data_wr = dv[i].wr; data_vaddr = dv[i].va;
            k0 = dv[i].k0v; entry_hi_W = {24'h0, dv[i].asid};
            @(negedge clk);
            check($sformatf("dv%0d_flags", i),
                  {data_tlb_refill, data_tlb_invalid, data_tlb_modify},
                  {dv[i].refill, dv[i].inv, dv[i].modify});
            if (dv[i].chk_pa) begin
                check($sformatf("dv%0d_paddr", i), data_paddr, dv[i].pa);
                check($sformatf("dv%0d_unc", i), data_uncached, dv[i].unc);
            end
        end
        data_req = 1'b0; data_wr = 1'b0; k0 = 3'd3;

        // Probe: hit, miss, and the all-zero entries where index 0 must win
        tlb_typeE = 4'b0001;
        entry_hi_W = 32'h00400005; #1; check("probe_hit", index_out, 32'h00000003);
        entry_hi_W = 32'h10000005; #1; check("probe_miss", index_out, 32'h80000000);
        entry_hi_W = 32'h00000000; #1; check("probe_lowest", index_out, 32'h00000000);

        // tlbr index 3, then tlbr low returns entry 0
        tlb_typeE = 4'b0010; index_W = 3; #1;
        check("tlbr_hi", entry_hi_out, 32'h00400005);
        check("tlbr_lo0", entry_lo0_out, 32'h00000001);
        check("tlbr_lo1", entry_lo1_out, 32'h0048D15B);
        check("tlbr_mask", page_mask_out, 32'h0001E000);
        tlb_typeE = 4'b0000; #1;
        check("tlbr_idle_hi", entry_hi_out, 32'h0);
        @(posedge clk); #1;

        // G is the AND of both lo words
        tlbw(1'b0, 6, 32'h00C00007, 32'h00000001, 32'h00000000, 32'h0, 1'b0);
        tlb_typeE = 4'b0010; index_W = 6; #1;
        check("g_and_lo0", entry_lo0_out, 32'h0);
        check("g_and_hi", entry_hi_out, 32'h00C00007);
        tlb_typeE = 4'b0000;

        // Duplicate match at index 1 takes priority over index 3
        tlbw(1'b0, 1, 32'h00400005, 32'h00000001, 32'h002AF357, 32'h0, 1'b0);
        data_req = 1'b1; data_vaddr = 32'h00401ABC;
        @(negedge clk);
        check("multi_paddr", data_paddr, 32'h0ABCDABC);
        check("multi_unc", data_uncached, 1'b1);
        tlb_typeE = 4'b0001; #1;
        check("multi_probe", index_out, 32'h00000001);
        tlb_typeE = 4'b0000; data_req = 1'b0;
        @(posedge clk); #1;

        // tlbwr under stall leaves entry 7 alone
        tlbw(1'b1, 7, 32'h00600005, 32'h00000003, 32'h00000003, 32'h0, 1'b1);
        tlb_typeE = 4'b0010; index_W = 7; #1;
        check("wr_stall_hi", entry_hi_out, 32'h0);
        // tlbwr with a same-cycle tlbr reads pre-write contents
        entry_hi_W = 32'h00600005; random_i = 7; tlb_typeE = 4'b1010;
        @(negedge clk);
        check("wr_same_cycle", entry_hi_out, 32'h0);
        @(posedge clk); #1;
        tlb_typeE = 4'b0010;
        #1;
        check("wr_after", entry_hi_out, 32'h00600005);
        tlb_typeE = 4'b0000;

`ifdef ITLB_CACHE_EN
        // A write committing during FILL must discard the fill
        entry_hi_W = 32'h00000005; inst_vaddr = 32'h00400ABC; inst_req = 1'b1;
        @(negedge clk);
        check("fillw_stall", inst_stall, 1'b1);
        @(posedge clk); #1;
        entry_lo0_W = 32'h00000001; entry_lo1_W = 32'h0048D15B; entry_hi_W = 32'h00400005;
        index_W = 3; tlb_typeE = 4'b0100;
        @(negedge clk);
        check("fillw_fill_stall", inst_stall, 1'b0);
        @(posedge clk); #1;
        tlb_typeE = 4'b0000; inst_req = 1'b0;
        fetch(32'h00400ABC, 8'd5, pa, unc, rf, iv, st);
        check("fillw_refetch_stall", st, 1);
        check("fillw_refetch_flags", {rf, iv}, 2'b01);

        // Async reset while in FILL
        inst_vaddr = 32'h00800ABC; inst_req = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; #1;
        check("rst_fill_stall", inst_stall, 1'b0);
        check("rst_fill_flags", {inst_tlb_refill, inst_tlb_invalid}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_fill_idle", inst_stall, 1'b1);
        @(posedge clk); #1;
        inst_req = 1'b0;
`endif

        // Final async reset mid-cycle clears flags and entries
        data_req = 1'b1; data_vaddr = 32'h10000000;
        @(negedge clk);
        check("pre_rst_refill", data_tlb_refill, 1'b1);
        #2 rst = 1'b0; #1;
        check("async_rst_flags", {data_tlb_refill, data_tlb_invalid, data_tlb_modify}, 0);
        tlb_typeE = 4'b0010; index_W = 3; #1;
        check("async_rst_entry", entry_hi_out, 32'h0);
        tlb_typeE = 4'b0000; data_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
